// File: rtl/match_report_tx.sv
// rtl/match_report_tx.sv - batch result packet transmitter for the MD5 match stage
module match_report_tx #(
    parameter int          MSG_CHARS    = 19,
    parameter logic [7:0]  STAT_MATCH   = 8'h01,
    parameter logic [7:0]  STAT_NOMATCH = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rpt_arm,
    input  logic        proc_done,
    input  logic        proc_match,
    input  logic [15:0] proc_byte_pos,
    input  logic [7:0]  proc_match_char,
    output logic        proc_match_char_next,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        rpt_busy,
    output logic        rpt_sent
);
    localparam int CW = (MSG_CHARS > 1) ? $clog2(MSG_CHARS) : 1;
    localparam logic [CW-1:0] LAST_CHAR = CW'(MSG_CHARS - 1);

    typedef enum logic [3:0] {
        IDLE,
        ARMED,
        WAIT_DONE,
        SEND_STAT,
        SEND_PHI,
        SEND_PLO,
        SEND_CHAR,
        CHAR_WAIT,
        FINISH
    } state_t;

    state_t         state, state_n;
    logic [7:0]     tx_data_n;
    logic           tx_valid_n;
    logic           next_n;
    logic           busy_n;
    logic           sent_n;
    logic [CW-1:0]  count, count_n;
    logic           match_q, match_n;
    logic [15:0]    pos_q, pos_n;
    logic           xfer;

    assign xfer = tx_valid & tx_ready;

    // State and every output are registered; reset abandons any packet in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            tx_data              <= 8'h00;
            tx_valid             <= 1'b0;
            proc_match_char_next <= 1'b0;
            rpt_busy             <= 1'b0;
            rpt_sent             <= 1'b0;
            count                <= '0;
            match_q              <= 1'b0;
            pos_q                <= 16'h0000;
        end else begin
            state                <= state_n;
            tx_data              <= tx_data_n;
            tx_valid             <= tx_valid_n;
            proc_match_char_next <= next_n;
            rpt_busy             <= busy_n;
            rpt_sent             <= sent_n;
            count                <= count_n;
            match_q              <= match_n;
            pos_q                <= pos_n;
        end
    end

    // Next-state and next-output decode; data/valid hold unless a transfer or load occurs.
    always_comb begin
        state_n    = state;
        tx_data_n  = tx_data;
        tx_valid_n = tx_valid;
        next_n     = 1'b0;
        busy_n     = rpt_busy;
        sent_n     = 1'b0;
        count_n    = count;
        match_n    = match_q;
        pos_n      = pos_q;
        case (state)
            // proc_done is not looked at here: the match stage reports done out of reset.
            IDLE: begin
                if (rpt_arm) begin
                    busy_n  = 1'b1;
                    state_n = ARMED;
                end
            end
            // One dead cycle lets the match stage drop its stale done flag.
            ARMED: state_n = WAIT_DONE;
            WAIT_DONE: begin
                if (proc_done) begin
                    match_n    = proc_match;
                    pos_n      = proc_byte_pos;
                    tx_data_n  = proc_match ? STAT_MATCH : STAT_NOMATCH;
                    tx_valid_n = 1'b1;
                    state_n    = SEND_STAT;
                end
            end
            SEND_STAT: begin
                if (xfer) begin
                    tx_data_n = pos_q[15:8];
                    state_n   = SEND_PHI;
                end
            end
            SEND_PHI: begin
                if (xfer) begin
                    tx_data_n = pos_q[7:0];
                    state_n   = SEND_PLO;
                end
            end
            SEND_PLO: begin
                if (xfer) begin
                    if (match_q) begin
                        tx_data_n = proc_match_char;
                        count_n   = '0;
                        state_n   = SEND_CHAR;
                    end else begin
                        tx_valid_n = 1'b0;
                        state_n    = FINISH;
                    end
                end
            end
            SEND_CHAR: begin
                if (xfer) begin
                    tx_valid_n = 1'b0;
                    if (count == LAST_CHAR) begin
                        state_n = FINISH;
                    end else begin
                        next_n  = 1'b1;
                        count_n = count + 1'b1;
                        state_n = CHAR_WAIT;
                    end
                end
            end
            // The advance strobe is visible during the first cycle here; the new head
            // character is only stable once the strobe has been taken, so load after it.
            CHAR_WAIT: begin
                if (!proc_match_char_next) begin
                    tx_data_n  = proc_match_char;
                    tx_valid_n = 1'b1;
                    state_n    = SEND_CHAR;
                end
            end
            FINISH: begin
                sent_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_match_report_tx.sv
// tb/tb_match_report_tx.sv - scoreboard bench for match_report_tx
module tb_match_report_tx;
    localparam int MSG_CHARS = 19;

    logic        clk = 1'b0;
    logic        reset;
    logic        rpt_arm;
    logic        proc_done;
    logic        proc_match;
    logic [15:0] proc_byte_pos;
    logic [7:0]  proc_match_char;
    logic        proc_match_char_next;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        rpt_busy;
    logic        rpt_sent;

    int          checks = 0;
    int          errors = 0;
    int          byte_cnt = 0;
    int          pulse_cnt = 0;
    int          sent_cnt = 0;
    logic [7:0]  expq[$];
    logic        hold_pend = 1'b0;
    logic [7:0]  hold_data = 8'h00;
    logic        bp_en = 1'b0;
    logic        char_rst = 1'b1;
    logic [7:0]  char_idx = 8'h00;
    int          low_left = 0;

    match_report_tx #(
        .MSG_CHARS   (MSG_CHARS),
        .STAT_MATCH  (8'h01),
        .STAT_NOMATCH(8'h00)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .rpt_arm             (rpt_arm),
        .proc_done           (proc_done),
        .proc_match          (proc_match),
        .proc_byte_pos       (proc_byte_pos),
        .proc_match_char     (proc_match_char),
        .proc_match_char_next(proc_match_char_next),
        .tx_data             (tx_data),
        .tx_valid            (tx_valid),
        .tx_ready            (tx_ready),
        .rpt_busy            (rpt_busy),
        .rpt_sent            (rpt_sent)
    );

    always #5 clk = ~clk;

    // Match-stage model: head character is 'A'+index, advancing on the edge after a strobe.
    assign proc_match_char = 8'h41 + char_idx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic char_model();
        forever begin
            @(posedge clk);
            if (char_rst) char_idx <= 8'h00;
            else if (proc_match_char_next) char_idx <= char_idx + 8'h01;
        end
    endtask

    task automatic ready_driver();
        forever begin
            @(posedge clk);
            #1;
            if (!bp_en) begin
                tx_ready = 1'b1;
            end else if (low_left > 0) begin
                tx_ready = 1'b0;
                low_left--;
            end else begin
                tx_ready = 1'b1;
                low_left = $urandom_range(0, 5);
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    check("hold_valid", tx_valid, 1);
                    check("hold_data", tx_data, hold_data);
                end
                hold_pend = tx_valid && !tx_ready;
                hold_data = tx_data;
                if (tx_valid && tx_ready) begin
                    byte_cnt++;
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $error("FAIL extra_byte: observed %0h expected none", tx_data);
                    end else begin
                        check("byte", tx_data, expq.pop_front());
                    end
                end
                if (proc_match_char_next) pulse_cnt++;
                if (rpt_sent) sent_cnt++;
            end
        end
    endtask

    task automatic arm();
        rpt_arm = 1'b1;
        @(posedge clk);
        #1;
        rpt_arm = 1'b0;
    endtask

    task automatic restart_chars();
        char_rst = 1'b1;
        @(posedge clk);
        #1;
        char_rst = 1'b0;
    endtask

    task automatic push_pkt(input logic m, input logic [15:0] pos);
        expq.push_back(m ? 8'h01 : 8'h00);
        expq.push_back(pos[15:8]);
        expq.push_back(pos[7:0]);
        if (m) for (int i = 0; i < MSG_CHARS; i++) expq.push_back(8'h41 + 8'(i));
    endtask

    // Waits for rpt_sent, optionally pulsing rpt_arm mid-packet, then audits the packet.
    task automatic finish_pkt(input int b0, input int p0, input int s0, input int nbytes,
                              input int npulses, input int arm_at, input string tag);
        bit did_arm = 0;
        bit done = 0;
        for (int c = 0; c < 1000 && !done; c++) begin
            @(posedge clk);
            #1;
            if (rpt_arm) rpt_arm = 1'b0;
            if (sent_cnt != s0) done = 1;
            else if (arm_at >= 0 && !did_arm && (byte_cnt - b0) >= arm_at && tx_valid) begin
                rpt_arm = 1'b1;
                did_arm = 1;
            end
        end
        rpt_arm = 1'b0;
        proc_done = 1'b0;
        check({tag, "_sent_seen"}, done, 1);
        check({tag, "_bytes"}, byte_cnt - b0, nbytes);
        check({tag, "_pulses"}, pulse_cnt - p0, npulses);
        check({tag, "_busy_low"}, rpt_busy, 0);
        check({tag, "_queue_left"}, expq.size(), 0);
        repeat (10) @(posedge clk);
        #1;
        check({tag, "_sent_once"}, sent_cnt - s0, 1);
        check({tag, "_idle_bytes"}, byte_cnt - b0, nbytes);
        check({tag, "_idle_busy"}, rpt_busy, 0);
        check({tag, "_idle_valid"}, tx_valid, 0);
    endtask

    task automatic send_pkt(input logic m, input logic [15:0] pos, input int arm_at,
                            input string tag);
        int b0;
        int p0;
        int s0;
        restart_chars();
        proc_match = m;
        proc_byte_pos = pos;
        proc_done = 1'b0;
        push_pkt(m, pos);
        b0 = byte_cnt;
        p0 = pulse_cnt;
        s0 = sent_cnt;
        arm();
        check({tag, "_busy_armed"}, rpt_busy, 1);
        @(posedge clk);
        #1;
        proc_done = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_stat_valid"}, tx_valid, 1);
        check({tag, "_stat_data"}, tx_data, m ? 8'h01 : 8'h00);
        proc_match = ~m;
        proc_byte_pos = ~pos;
        finish_pkt(b0, p0, s0, m ? 3 + MSG_CHARS : 3, m ? MSG_CHARS - 1 : 0, arm_at, tag);
    endtask

    initial begin
        int b0;
        int p0;
        int s0;
        bit hit;
        reset = 1'b1;
        rpt_arm = 1'b0;
        proc_done = 1'b0;
        proc_match = 1'b0;
        proc_byte_pos = 16'h0000;
        tx_ready = 1'b1;
        fork
            char_model();
            ready_driver();
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_next", proc_match_char_next, 0);
        check("rst_busy", rpt_busy, 0);
        check("rst_sent", rpt_sent, 0);
        reset = 1'b0;
        // proc_done high out of reset must not start anything while unarmed.
        proc_done = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("idle_ignores_done", byte_cnt, 0);
        proc_done = 1'b0;

        send_pkt(1'b1, 16'h0123, -1, "match");
        send_pkt(1'b0, 16'h0000, -1, "nomatch");
        bp_en = 1'b1;
        send_pkt(1'b1, 16'h0123, -1, "backpressure");
        bp_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Stale done: high through arm and the ARMED cycle, then low, then a real rise.
        restart_chars();
        proc_match = 1'b0;
        proc_byte_pos = 16'h0000;
        proc_done = 1'b1;
        b0 = byte_cnt;
        p0 = pulse_cnt;
        s0 = sent_cnt;
        arm();
        @(posedge clk);
        #1;
        proc_done = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("stale_quiet_bytes", byte_cnt - b0, 0);
        check("stale_quiet_valid", tx_valid, 0);
        check("stale_busy", rpt_busy, 1);
        push_pkt(1'b0, 16'hFFFF);
        proc_byte_pos = 16'hFFFF;
        proc_done = 1'b1;
        finish_pkt(b0, p0, s0, 3, 0, -1, "stale");

        // Reset while the sixth byte of a match packet is on the bus.
        restart_chars();
        proc_match = 1'b1;
        proc_byte_pos = 16'h0123;
        push_pkt(1'b1, 16'h0123);
        b0 = byte_cnt;
        arm();
        @(posedge clk);
        #1;
        proc_done = 1'b1;
        hit = 0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(posedge clk);
            #1;
            if (byte_cnt - b0 == 5) hit = 1;
        end
        check("rst_mid_reached", hit, 1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_mid_pre_valid", tx_valid, 1);
        check("rst_mid_pre_data", tx_data, 8'h43);
        reset = 1'b1;
        #1;
        check("rst_mid_valid", tx_valid, 0);
        check("rst_mid_busy", rpt_busy, 0);
        expq.delete();
        proc_done = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_pkt(1'b1, 16'h0123, -1, "rearm");

        // Arm pulse while a character byte is pending must be ignored.
        send_pkt(1'b1, 16'h0456, 5, "arm_busy");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
